// File: rtl/icache_flush_unit_if.sv
// Bundle between the PC stage / icache refill path and the icache flush unit:
// flush commands, fetch-PC lookup, refill writes and the flush status returned to ctrl.
interface icache_flush_unit_if #(
  parameter int ADDR_W = 32,
  parameter int WAYS   = 2,
  parameter int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1
);
  // No valid/ready pairs here. IcacheFlash/IcacheFlashAll are levels held by the PC stage,
  // and the unit reacts to a rise or an entry change. FillAble is a one-cycle write strobe
  // that is only legal while FlushBusy=0. Outputs are all registered.
  logic              IcacheFlash;
  logic              IcacheFlashAll;
  logic [ADDR_W-1:0] IcacheFlashEnty;
  logic [ADDR_W-1:0] PcDate;
  logic              FillAble;
  logic [WAY_W-1:0]  FillWay;
  logic [ADDR_W-1:0] FillAddr;
  logic [WAYS-1:0]   LookupValid;
  logic              FlushBusy;
  logic              FlushDone;
  logic [1:0]        DbgState;

  modport master (
    output IcacheFlash, IcacheFlashAll, IcacheFlashEnty, PcDate, FillAble, FillWay, FillAddr,
    input  LookupValid, FlushBusy, FlushDone, DbgState
  );

  modport slave (
    input  IcacheFlash, IcacheFlashAll, IcacheFlashEnty, PcDate, FillAble, FillWay, FillAddr,
    output LookupValid, FlushBusy, FlushDone, DbgState
  );
endinterface

// File: rtl/icache_flush_unit.sv
// ICache line-valid array owner: single-set and full invalidation on PC-stage flush commands,
// registered valid lookup for the fetch PC, and refill valid-bit writes.
module icache_flush_unit #(
  parameter int SETS     = 64,
  parameter int WAYS     = 2,
  parameter int OFFSET_W = 4,
  parameter int ADDR_W   = 32
) (
  input logic                Clk,
  input logic                Rest,
  icache_flush_unit_if.slave Bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(SETS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    WALK  = 2'd2
  } state_t;

  state_t            State;
  logic [WAYS-1:0]   ValidArr [SETS];
  logic [IDX_W-1:0]  WalkCnt;
  logic [IDX_W-1:0]  TargetIdx;
  logic              PrevFlash;
  logic              PrevAll;
  logic [ADDR_W-1:0] PrevEnty;
  logic [WAYS-1:0]   LookupQ;
  logic              BusyQ;
  logic              DoneQ;

  logic [IDX_W-1:0]  PcIdx;
  logic [IDX_W-1:0]  FillIdx;
  logic [IDX_W-1:0]  EntyIdx;
  logic [WAY_W-1:0]  FillWaySel;
  logic              NewAll;
  logic              NewEntry;

  assign PcIdx      = Bus.PcDate[OFFSET_W +: IDX_W];
  assign FillIdx    = Bus.FillAddr[OFFSET_W +: IDX_W];
  assign EntyIdx    = Bus.IcacheFlashEnty[OFFSET_W +: IDX_W];
  assign FillWaySel = Bus.FillWay;

  // Commands are levels: only a rising All, or a rising/retargeted Flash, starts work.
  assign NewAll   = Bus.IcacheFlashAll & ~PrevAll;
  assign NewEntry = Bus.IcacheFlash & (~PrevFlash | (Bus.IcacheFlashEnty != PrevEnty));

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      State     <= IDLE;
      WalkCnt   <= '0;
      TargetIdx <= '0;
      PrevFlash <= 1'b0;
      PrevAll   <= 1'b0;
      PrevEnty  <= '0;
      LookupQ   <= '0;
      BusyQ     <= 1'b0;
      DoneQ     <= 1'b0;
      for (int s = 0; s < SETS; s++) ValidArr[s] <= '0;
    end else begin
      // Old array contents are read, so a same-edge fill shows up one cycle later.
      LookupQ <= BusyQ ? '0 : ValidArr[PcIdx];
      unique case (State)
        IDLE: begin
          PrevFlash <= Bus.IcacheFlash;
          PrevAll   <= Bus.IcacheFlashAll;
          PrevEnty  <= Bus.IcacheFlashEnty;
          if (Bus.FillAble) ValidArr[FillIdx][FillWaySel] <= 1'b1;
          if (NewAll) begin
            State   <= WALK;
            WalkCnt <= '0;
            BusyQ   <= 1'b1;
            DoneQ   <= (SETS == 1);
          end else if (NewEntry) begin
            State     <= ENTRY;
            TargetIdx <= EntyIdx;
            BusyQ     <= 1'b1;
            DoneQ     <= 1'b1;
          end
        end
        ENTRY: begin
          ValidArr[TargetIdx] <= '0;
          State <= IDLE;
          BusyQ <= 1'b0;
          DoneQ <= 1'b0;
        end
        WALK: begin
          ValidArr[WalkCnt] <= '0;
          if (WalkCnt == LAST_SET) begin
            State   <= IDLE;
            WalkCnt <= '0;
            BusyQ   <= 1'b0;
            DoneQ   <= 1'b0;
          end else begin
            WalkCnt <= WalkCnt + 1'b1;
            DoneQ   <= (WalkCnt == LAST_SET - 1'b1);
          end
        end
        default: begin
          State <= IDLE;
          BusyQ <= 1'b0;
          DoneQ <= 1'b0;
        end
      endcase
    end
  end

  assign Bus.LookupValid = LookupQ;
  assign Bus.FlushBusy   = BusyQ;
  assign Bus.FlushDone   = DoneQ;
  assign Bus.DbgState    = State;
endmodule

// File: tb/tb_icache_flush_unit.sv
// Directed bench for icache_flush_unit: boot walk, fills/lookups, entry flushes,
// All-vs-entry priority and reset in the middle of a walk.
module tb_icache_flush_unit;
  logic Clk;
  logic Rest;
  int   n_cmp;
  int   n_err;
  int   fill_viol;
  logic [1:0] mdl [64];
  logic [31:0] exp_q[$];

  icache_flush_unit_if #(.ADDR_W(32), .WAYS(2)) bus ();

  icache_flush_unit #(.SETS(64), .WAYS(2), .OFFSET_W(4), .ADDR_W(32)) dut (
    .Clk (Clk),
    .Rest(Rest),
    .Bus (bus)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  // the refill side must never write while a flush is running
  initial fill_viol = 0;
  always @(negedge Clk) begin
    if (Rest === 1'b1 && bus.FillAble === 1'b1 && bus.FlushBusy === 1'b1) fill_viol++;
  end

  // driver / checker tasks
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic way, input logic [31:0] addr);
    bus.FillAble = 1'b1;
    bus.FillWay  = way;
    bus.FillAddr = addr;
    mdl[addr[9:4]][way] = 1'b1;
    cyc();
    bus.FillAble = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] addr);
    bus.PcDate = addr;
    exp_q.push_back({30'd0, mdl[addr[9:4]]});
    cyc();
    chk(tag, {30'd0, bus.LookupValid}, exp_q.pop_front());
  endtask

  task automatic watch(input int n, output int nb, output int nd, output int first_b,
                       output int done_at, output int nz);
    logic was_busy;
    was_busy = 1'b0;
    nb = 0; nd = 0; first_b = -1; done_at = -1; nz = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      if (was_busy && bus.LookupValid !== 2'b00) nz++;
      if (bus.FlushBusy === 1'b1) begin
        nb++;
        if (first_b < 0) first_b = i;
      end
      if (bus.FlushDone === 1'b1) begin
        nd++;
        done_at = i;
      end
      was_busy = (bus.FlushBusy === 1'b1);
    end
    cyc();
  endtask

  task automatic clear_mdl();
    for (int s = 0; s < 64; s++) mdl[s] = 2'b00;
  endtask

  // directed sequence
  initial begin
    int nb, nd, fb, da, nz;
    n_cmp = 0;
    n_err = 0;
    clear_mdl();
    Rest = 1'b0;
    bus.IcacheFlash     = 1'b0;
    bus.IcacheFlashAll  = 1'b1;
    bus.IcacheFlashEnty = '0;
    bus.PcDate          = '0;
    bus.FillAble        = 1'b0;
    bus.FillWay         = 1'b0;
    bus.FillAddr        = '0;
    #2;
    chk("rst_lookup", {30'd0, bus.LookupValid}, 32'd0);
    chk("rst_busy", {31'd0, bus.FlushBusy}, 32'd0);
    chk("rst_done", {31'd0, bus.FlushDone}, 32'd0);

    // boot walk with All held high, no second walk
    cyc();
    Rest = 1'b1;
    watch(110, nb, nd, fb, da, nz);
    chk("boot_busy_cycles", nb, 64);
    chk("boot_first_busy", fb, 1);
    chk("boot_done_pulses", nd, 1);
    chk("boot_done_last", da, 64);
    bus.IcacheFlashAll = 1'b0;
    cyc();

    // fill then lookup, and read-before-write on a same-cycle fill
    fill(1'b1, 32'h50);
    look("lookup_set5_way1", 32'h50);
    bus.PcDate   = 32'h50;
    bus.FillAble = 1'b1;
    bus.FillWay  = 1'b0;
    bus.FillAddr = 32'h50;
    exp_q.push_back({30'd0, mdl[5]});
    mdl[5][0] = 1'b1;
    cyc();
    bus.FillAble = 1'b0;
    chk("lookup_rbw_old", {30'd0, bus.LookupValid}, exp_q.pop_front());
    look("lookup_rbw_new", 32'h50);

    // entry flush on a high address aliasing set 5
    fill(1'b0, 32'h60);
    bus.IcacheFlash     = 1'b1;
    bus.IcacheFlashEnty = 32'h1C050;
    watch(4, nb, nd, fb, da, nz);
    mdl[5] = 2'b00;
    chk("entry_busy_cycles", nb, 1);
    chk("entry_first_busy", fb, 1);
    chk("entry_done_pulses", nd, 1);
    chk("entry_done_at", da, 1);
    look("entry_set5_cleared", 32'h50);
    look("entry_set6_kept", 32'h60);

    // Flash held high while the entry address changes
    fill(1'b1, 32'h50);
    fill(1'b1, 32'h60);
    look("refill_set5", 32'h50);
    look("refill_set6", 32'h60);
    bus.IcacheFlashEnty = 32'h50;
    watch(4, nb, nd, fb, da, nz);
    mdl[5] = 2'b00;
    chk("retarget1_busy", nb, 1);
    chk("retarget1_done", nd, 1);
    bus.IcacheFlashEnty = 32'h60;
    watch(4, nb, nd, fb, da, nz);
    mdl[6] = 2'b00;
    chk("retarget2_busy", nb, 1);
    chk("retarget2_done", nd, 1);
    watch(6, nb, nd, fb, da, nz);
    chk("held_no_repeat", nb, 0);
    look("retarget_set5", 32'h50);
    look("retarget_set6", 32'h60);
    bus.IcacheFlash = 1'b0;
    cyc();

    // Flash and All rising together: walk only
    fill(1'b0, 32'h70);
    fill(1'b1, 32'h3F0);
    look("pre_walk_set7", 32'h70);
    bus.IcacheFlash     = 1'b1;
    bus.IcacheFlashEnty = 32'h70;
    bus.IcacheFlashAll  = 1'b1;
    watch(100, nb, nd, fb, da, nz);
    clear_mdl();
    chk("both_busy_cycles", nb, 64);
    chk("both_first_busy", fb, 1);
    chk("both_done_pulses", nd, 1);
    chk("both_done_last", da, 64);
    chk("both_lookup_zero_busy", nz, 0);
    look("both_set7", 32'h70);
    look("both_set63", 32'h3F0);
    bus.IcacheFlash    = 1'b0;
    bus.IcacheFlashAll = 1'b0;
    cyc();

    // reset while WalkCnt=20
    fill(1'b0, 32'h90);
    fill(1'b1, 32'h3F0);
    look("pre_rst_set63", 32'h3F0);
    bus.IcacheFlashAll = 1'b1;
    for (int k = 0; k < 21; k++) cyc();
    chk("busy_before_rst", {31'd0, bus.FlushBusy}, 32'd1);
    chk("state_walk_before_rst", {30'd0, bus.DbgState}, 32'd2);
    #2;
    Rest = 1'b0;
    bus.IcacheFlashAll = 1'b0;
    #1;
    clear_mdl();
    chk("midrst_busy", {31'd0, bus.FlushBusy}, 32'd0);
    chk("midrst_done", {31'd0, bus.FlushDone}, 32'd0);
    chk("midrst_lookup", {30'd0, bus.LookupValid}, 32'd0);
    cyc();
    Rest = 1'b1;
    watch(5, nb, nd, fb, da, nz);
    chk("post_rst_busy", nb, 0);
    chk("post_rst_done", nd, 0);
    for (int s = 0; s < 64; s++) look("post_rst_set", s << 4);

    chk("no_fill_while_busy", fill_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
